// File: rtl/ss_store_buffer_unit.sv
// Store unit: translate/SS-check one staged store, buffer it speculatively,
// promote on commit and drain committed entries in order to the D$.
module ss_store_buffer_unit #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned PLEN          = 56,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter bit          SS_CHECK      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     ss_push_i,
  output logic                     translation_req_o,
  output logic [XLEN-1:0]          vaddr_o,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     dtlb_hit_i,
  input  logic                     ex_valid_i,
  input  logic [PLEN-1:0]          ss_base_i,
  input  logic [PLEN-1:0]          ss_limit_i,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     ex_valid_o,
  output logic                     ex_ss_o,
  input  logic                     commit_i,
  output logic                     commit_ready_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [PLEN-1:0]          mem_addr_o,
  output logic [XLEN-1:0]          mem_data_o,
  output logic [XLEN/8-1:0]        mem_be_o,
  output logic [1:0]               mem_size_o,
  output logic                     mem_ss_o,
  output logic                     no_st_pending_o,
  output logic                     empty_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, TRANSLATE} state_e;

  state_e                   r_state;
  logic [XLEN-1:0]          r_st_vaddr;
  logic [XLEN-1:0]          r_st_data;
  logic [BE_W-1:0]          r_st_be;
  logic [1:0]               r_st_size;
  logic [TRANS_ID_BITS-1:0] r_st_id;
  logic                     r_st_ss;

  logic [PLEN-1:0]          r_addr [DEPTH];
  logic [XLEN-1:0]          r_data [DEPTH];
  logic [BE_W-1:0]          r_be   [DEPTH];
  logic [1:0]               r_size [DEPTH];
  logic                     r_ss   [DEPTH];

  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_cmt_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_spec_cnt;
  logic [CNT_W-1:0]         r_cmt_cnt;

  logic [CNT_W-1:0]         w_total;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_in_xlate;
  logic                     w_resolve;
  logic                     w_in_region;
  logic                     w_ss_fault;
  logic                     w_wr;
  logic                     w_commit;
  logic                     w_gnt;
  logic                     w_mem_req;

  assign w_total     = r_spec_cnt + r_cmt_cnt;
  assign w_ready     = (r_state == IDLE) && (w_total < CNT_W'(DEPTH)) && !flush_i;
  assign w_accept    = valid_i && w_ready;
  assign w_in_xlate  = (r_state == TRANSLATE);
  // A flush swallows the in-flight request: no writeback, no write.
  assign w_resolve   = w_in_xlate && (ex_valid_i || dtlb_hit_i) && !flush_i;
  assign w_in_region = (paddr_i >= ss_base_i) && (paddr_i < ss_limit_i);
  assign w_ss_fault  = SS_CHECK && r_st_ss && !w_in_region;
  assign w_wr        = w_resolve && !ex_valid_i && !w_ss_fault;
  assign w_commit    = commit_i && (r_spec_cnt != '0);
  assign w_gnt       = mem_gnt_i && (r_cmt_cnt != '0);
  assign w_mem_req   = (r_cmt_cnt != '0);

  // Request FSM and staging register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_st_vaddr <= '0;
      r_st_data  <= '0;
      r_st_be    <= '0;
      r_st_size  <= '0;
      r_st_id    <= '0;
      r_st_ss    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_st_vaddr <= vaddr_i;
            r_st_data  <= data_i;
            r_st_be    <= be_i;
            r_st_size  <= size_i;
            r_st_id    <= trans_id_i;
            r_st_ss    <= ss_push_i;
            r_state    <= TRANSLATE;
          end
        end
        TRANSLATE: begin
          if (flush_i || ex_valid_i || dtlb_hit_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Entry storage; validity is tracked by pointers and counters
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_addr[r_wr_ptr] <= paddr_i;
      r_data[r_wr_ptr] <= r_st_data;
      r_be[r_wr_ptr]   <= r_st_be;
      r_size[r_wr_ptr] <= r_st_size;
      r_ss[r_wr_ptr]   <= r_st_ss;
    end
  end

  // Pointers and occupancy; a same-cycle commit is applied before a flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_spec_cnt <= '0;
      r_cmt_cnt  <= '0;
    end else begin
      if (w_gnt)    r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      if (w_commit) r_cmt_ptr <= r_cmt_ptr + PTR_W'(1);
      r_cmt_cnt <= r_cmt_cnt + CNT_W'(w_commit) - CNT_W'(w_gnt);
      if (flush_i) begin
        r_spec_cnt <= '0;
        r_wr_ptr   <= r_cmt_ptr + PTR_W'(w_commit);
      end else begin
        r_spec_cnt <= r_spec_cnt + CNT_W'(w_wr) - CNT_W'(w_commit);
        if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  assign ready_o           = w_ready;
  assign translation_req_o = w_in_xlate;
  assign vaddr_o           = w_in_xlate ? r_st_vaddr : '0;
  assign valid_o           = w_resolve;
  assign trans_id_o        = w_resolve ? r_st_id : '0;
  assign ex_valid_o        = w_resolve && (ex_valid_i || w_ss_fault);
  assign ex_ss_o           = w_resolve && !ex_valid_i && w_ss_fault;
  assign commit_ready_o    = (r_spec_cnt != '0);
  assign mem_req_o         = w_mem_req;
  assign mem_addr_o        = w_mem_req ? r_addr[r_rd_ptr] : '0;
  assign mem_data_o        = w_mem_req ? r_data[r_rd_ptr] : '0;
  assign mem_be_o          = w_mem_req ? r_be[r_rd_ptr]   : '0;
  assign mem_size_o        = w_mem_req ? r_size[r_rd_ptr] : '0;
  assign mem_ss_o          = w_mem_req && r_ss[r_rd_ptr];
  assign no_st_pending_o   = (r_cmt_cnt == '0) && (r_state == IDLE);
  assign empty_o           = (w_total == '0);

endmodule
